// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter_pkg
// Brief    : Shared types and constants for the IF/LSB memory request arbiter.
//            Optional feature macro used by the arbiter: ARB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package mem_req_arbiter_pkg;

    localparam int ADDR_TYPE = 32;
    localparam int DATA_TYPE = 32;
    localparam int LS_TYPE   = 3;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // Address bits [17:16] == 2'b11 select the memory-mapped IO (UART) region
    localparam logic [1:0] IO_REGION = 2'b11;

    // Size code for a full 4-byte access; instruction fetch always uses it
    localparam logic [LS_TYPE-1:0] LS_WORD = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_IF = 3'd1,
        GNT_LD = 3'd2,
        GNT_ST = 3'd3,
        ABORT  = 3'd4,
        GAP    = 3'd5
    } arb_state_t;

    function automatic logic is_io_addr(input logic [ADDR_TYPE-1:0] addr);
        return addr[17:16] == IO_REGION;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter_if
// Brief    : Requester, control and memory-controller signals of the arbiter.
//            master = arbiter view, slave = environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_req_arbiter_if;
    import mem_req_arbiter_pkg::*;

    logic                 rdy;
    logic                 clr;
    logic                 io_buffer_full;

    logic                 if_req;
    logic [ADDR_TYPE-1:0] if_addr;
    logic                 if_done;
    logic [DATA_TYPE-1:0] if_rdata;

    logic                 lsb_req;
    logic                 lsb_wr;
    logic [ADDR_TYPE-1:0] lsb_addr;
    logic [LS_TYPE-1:0]   lsb_ls_type;
    logic [DATA_TYPE-1:0] lsb_st_val;
    logic                 lsb_done;
    logic [DATA_TYPE-1:0] lsb_rdata;

    logic                 mc_enable;
    logic                 mc_wr;
    logic [ADDR_TYPE-1:0] mc_addr;
    logic [LS_TYPE-1:0]   mc_ls_type;
    logic [DATA_TYPE-1:0] mc_st_val;
    logic                 mc_done;
    logic [DATA_TYPE-1:0] mc_rdata;

    modport master (
        input  rdy, clr, io_buffer_full,
        input  if_req, if_addr,
        output if_done, if_rdata,
        input  lsb_req, lsb_wr, lsb_addr, lsb_ls_type, lsb_st_val,
        output lsb_done, lsb_rdata,
        output mc_enable, mc_wr, mc_addr, mc_ls_type, mc_st_val,
        input  mc_done, mc_rdata
    );

    modport slave (
        output rdy, clr, io_buffer_full,
        output if_req, if_addr,
        input  if_done, if_rdata,
        output lsb_req, lsb_wr, lsb_addr, lsb_ls_type, lsb_st_val,
        input  lsb_done, lsb_rdata,
        input  mc_enable, mc_wr, mc_addr, mc_ls_type, mc_st_val,
        output mc_done, mc_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter_age.sv
`default_nettype none
// ============================================================================
// Module   : arb_age_counter
// Brief    : Saturating count of LSB grants taken while IF waits; flags when
//            IF must be promoted ahead of the LSB.
// Revision : 1.0 - initial release
// ============================================================================
module arb_age_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AGE_W        = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_en,
    input  wire logic i_inc,
    input  wire logic i_clr,
    output logic      o_ge_limit
);

    localparam logic [AGE_W-1:0] AGE_MAX   = '1;
    localparam logic [AGE_W-1:0] AGE_ONE   = {{(AGE_W-1){1'b0}}, 1'b1};
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] r_age;

    // Clear wins over increment; the count sticks at its maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_age <= '0;
            end else if (i_inc && (r_age != AGE_MAX)) begin
                r_age <= r_age + AGE_ONE;
            end
        end
    end

    assign o_ge_limit = (r_age >= AGE_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Brief    : Shares the byte-serial memory controller between instruction
//            fetch and the load/store buffer. LSB priority with starvation
//            promotion for IF, IO-full store gating, pipeline-clear aborts.
//            Optional macro ARB_PERF_CNT_EN adds four performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AGE_W        = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_req_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_lsb_grants,
    output logic [31:0]       perf_starve_promotions,
    output logic [31:0]       perf_io_stall_cycles
`endif
);

    arb_state_t           r_state;
    arb_state_t           w_next_state;

    logic                 w_io_blocked;
    logic                 w_lsb_eligible;
    logic                 w_age_ge;
    logic                 w_grant_if;
    logic                 w_grant_lsb;
    logic                 w_if_cmpl;
    logic                 w_lsb_cmpl;

    logic                 r_mc_wr;
    logic [ADDR_TYPE-1:0] r_mc_addr;
    logic [LS_TYPE-1:0]   r_mc_ls_type;
    logic [DATA_TYPE-1:0] r_mc_st_val;
    logic                 r_if_done;
    logic [DATA_TYPE-1:0] r_if_rdata;
    logic                 r_lsb_done;
    logic [DATA_TYPE-1:0] r_lsb_rdata;

    // Stores into the UART region must wait while its buffer is full
    assign w_io_blocked   = bus.lsb_wr && is_io_addr(bus.lsb_addr) && bus.io_buffer_full;
    assign w_lsb_eligible = bus.lsb_req && !w_io_blocked;

    arb_age_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .AGE_W        (AGE_W)
    ) u_age (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (bus.rdy),
        .i_inc      (w_grant_lsb && bus.if_req),
        .i_clr      (w_grant_if || !bus.if_req),
        .o_ge_limit (w_age_ge)
    );

    // State register; rdy low freezes the machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (bus.rdy) begin
            r_state <= w_next_state;
        end
    end

    // Arbitration, completion and abort decisions
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_lsb  = 1'b0;
        w_if_cmpl    = 1'b0;
        w_lsb_cmpl   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.clr) begin
                    if (bus.if_req && (!w_lsb_eligible || w_age_ge)) begin
                        w_grant_if   = 1'b1;
                        w_next_state = GNT_IF;
                    end else if (w_lsb_eligible) begin
                        w_grant_lsb  = 1'b1;
                        w_next_state = bus.lsb_wr ? GNT_ST : GNT_LD;
                    end
                end
            end
            GNT_IF: begin
                if (bus.clr) begin
                    w_next_state = bus.mc_done ? GAP : ABORT;
                end else if (bus.mc_done) begin
                    w_if_cmpl    = 1'b1;
                    w_next_state = GAP;
                end
            end
            GNT_LD: begin
                if (bus.clr) begin
                    w_next_state = bus.mc_done ? GAP : ABORT;
                end else if (bus.mc_done) begin
                    w_lsb_cmpl   = 1'b1;
                    w_next_state = GAP;
                end
            end
            // A store already issued cannot be undone, so clr is ignored here
            GNT_ST: begin
                if (bus.mc_done) begin
                    w_lsb_cmpl   = 1'b1;
                    w_next_state = GAP;
                end
            end
            ABORT: begin
                if (bus.mc_done) begin
                    w_next_state = GAP;
                end
            end
            GAP:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the granted request and produce registered done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mc_wr      <= MEM_READ;
            r_mc_addr    <= '0;
            r_mc_ls_type <= '0;
            r_mc_st_val  <= '0;
            r_if_done    <= 1'b0;
            r_if_rdata   <= '0;
            r_lsb_done   <= 1'b0;
            r_lsb_rdata  <= '0;
        end else if (bus.rdy) begin
            r_if_done  <= w_if_cmpl;
            r_lsb_done <= w_lsb_cmpl;
            if (w_if_cmpl) begin
                r_if_rdata <= bus.mc_rdata;
            end
            if (w_lsb_cmpl) begin
                r_lsb_rdata <= (r_state == GNT_ST) ? '0 : bus.mc_rdata;
            end
            if (w_grant_if) begin
                r_mc_wr      <= MEM_READ;
                r_mc_addr    <= bus.if_addr;
                r_mc_ls_type <= LS_WORD;
                r_mc_st_val  <= '0;
            end else if (w_grant_lsb) begin
                r_mc_wr      <= bus.lsb_wr ? MEM_WRITE : MEM_READ;
                r_mc_addr    <= bus.lsb_addr;
                r_mc_ls_type <= bus.lsb_ls_type;
                r_mc_st_val  <= bus.lsb_wr ? bus.lsb_st_val : '0;
            end
        end
    end

    // Aborted reads keep the controller enabled until it finishes
    assign bus.mc_enable  = (r_state == GNT_IF) || (r_state == GNT_LD) ||
                            (r_state == GNT_ST) || (r_state == ABORT);
    assign bus.mc_wr      = r_mc_wr;
    assign bus.mc_addr    = r_mc_addr;
    assign bus.mc_ls_type = r_mc_ls_type;
    assign bus.mc_st_val  = r_mc_st_val;
    assign bus.if_done    = r_if_done;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.lsb_done   = r_lsb_done;
    assign bus.lsb_rdata  = r_lsb_rdata;

`ifdef ARB_PERF_CNT_EN
    // Wrapping event counters, frozen together with the rest of the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_grants         <= '0;
            perf_lsb_grants        <= '0;
            perf_starve_promotions <= '0;
            perf_io_stall_cycles   <= '0;
        end else if (bus.rdy) begin
            if (w_grant_if) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (w_grant_lsb) begin
                perf_lsb_grants <= perf_lsb_grants + 32'd1;
            end
            if (w_grant_if && w_lsb_eligible) begin
                perf_starve_promotions <= perf_starve_promotions + 32'd1;
            end
            if ((r_state == IDLE) && bus.lsb_req && w_io_blocked) begin
                perf_io_stall_cycles <= perf_io_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Brief    : Scoreboard bench for mem_req_arbiter with a behavioural memory
//            controller; directed scenarios with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  ls;
        logic [31:0] st;
    } req_t;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
    } done_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_arbiter_if bus();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants, perf_lsb_grants, perf_starve_promotions, perf_io_stall_cycles;
`endif

    mem_req_arbiter #(
        .STARVE_LIMIT (4),
        .AGE_W        (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_grants         (perf_if_grants),
        .perf_lsb_grants        (perf_lsb_grants),
        .perf_starve_promotions (perf_starve_promotions),
        .perf_io_stall_cycles   (perf_io_stall_cycles)
`endif
    );

    req_t  req_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    int    mc_lat = 5;
    logic [31:0] mc_data = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic [31:0] a, input logic w, input logic [2:0] l, input logic [31:0] s);
        req_t r;
        r.addr = a; r.wr = w; r.ls = l; r.st = s;
        req_q.push_back(r);
    endtask

    task automatic exp_done(input logic is_if, input logic [31:0] d);
        done_t e;
        e.is_if = is_if; e.data = d;
        done_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // sel: 0 if_done, 1 lsb_done, 2 mc_enable high
    task automatic wait_for(input int sel, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 300) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = bus.if_done;
                1:       hit = bus.lsb_done;
                default: hit = bus.mc_enable;
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: event absent after %0d cycles, required within 300", name, n);
        end
    endtask

    // Memory controller model: mc_done after mc_lat enabled cycles, held until taken
    initial begin
        int cnt;
        cnt = 0;
        bus.mc_done  = 1'b0;
        bus.mc_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mc_done) begin
                if (!bus.mc_enable) begin
                    bus.mc_done = 1'b0;
                    cnt = 0;
                end
            end else if (bus.mc_enable) begin
                cnt++;
                if (cnt >= mc_lat) begin
                    bus.mc_done  = 1'b1;
                    bus.mc_rdata = mc_data;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Done monitor: every done pulse must match the next expected completion
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (bus.if_done || bus.lsb_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got if_done=%b lsb_done=%b, required none", bus.if_done, bus.lsb_done);
                end else begin
                    e = done_q.pop_front();
                    check32("done_source", {30'b0, bus.if_done, bus.lsb_done}, {30'b0, e.is_if, !e.is_if});
                    check32("done_rdata", bus.if_done ? bus.if_rdata : bus.lsb_rdata, e.data);
                end
            end
        end
    end

    // Request monitor: each new grant matches the queue, stays stable, follows a gap
    initial begin
        req_t cur;
        logic prev_en;
        int   low_run;
        prev_en = 1'b0;
        low_run = 2;
        cur.addr = '0; cur.wr = 1'b0; cur.ls = '0; cur.st = '0;
        forever begin
            @(negedge clk);
            if (bus.mc_enable && !prev_en) begin
                check32("gap_before_grant", (low_run >= 2) ? 32'd1 : 32'd0, 32'd1);
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got mc_addr=%h, required no grant", bus.mc_addr);
                end else begin
                    cur = req_q.pop_front();
                    check32("mc_addr", bus.mc_addr, cur.addr);
                    check32("mc_wr", 32'(bus.mc_wr), 32'(cur.wr));
                    check32("mc_ls_type", 32'(bus.mc_ls_type), 32'(cur.ls));
                    check32("mc_st_val", bus.mc_st_val, cur.st);
                end
            end else if (bus.mc_enable) begin
                check32("mc_addr_stable", bus.mc_addr, cur.addr);
                check32("mc_st_val_stable", bus.mc_st_val, cur.st);
            end
            low_run = bus.mc_enable ? 0 : low_run + 1;
            prev_en = bus.mc_enable;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required earlier finish", $time);
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        bus.rdy = 1'b1; bus.clr = 1'b0; bus.io_buffer_full = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0;
        bus.lsb_ls_type = '0; bus.lsb_st_val = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check32("rst_mc_enable", 32'(bus.mc_enable), 32'd0);
        check32("rst_if_done", 32'(bus.if_done), 32'd0);
        check32("rst_lsb_done", 32'(bus.lsb_done), 32'd0);
        check32("rst_mc_addr", bus.mc_addr, 32'd0);
        check32("rst_mc_ls_type", 32'(bus.mc_ls_type), 32'd0);
        check32("rst_state", 32'(dut.r_state), 32'(IDLE));
        check32("rst_age", 32'(dut.u_age.r_age), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // IF alone
        mc_lat = 5; mc_data = 32'hDEADBEEF;
        exp_req(32'h100, MEM_READ, LS_WORD, 32'h0);
        exp_done(1'b1, 32'hDEADBEEF);
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        wait_for(0, "if_only");
        check32("gap_mc_enable", 32'(bus.mc_enable), 32'd0);
        tick();
        bus.if_req = 1'b0;
        repeat (2) tick();

        // Starvation: four LSB loads, then IF promoted, then LSB wins again with age 0
        mc_lat = 3; mc_data = 32'h11112222;
        for (int i = 0; i < 4; i++) begin
            exp_req(32'h2000, MEM_READ, 3'd2, 32'h0);
            exp_done(1'b0, 32'h11112222);
        end
        exp_req(32'h400, MEM_READ, LS_WORD, 32'h0);
        exp_done(1'b1, 32'h11112222);
        exp_req(32'h2000, MEM_READ, 3'd2, 32'h0);
        exp_done(1'b0, 32'h11112222);
        exp_req(32'h404, MEM_READ, LS_WORD, 32'h0);
        exp_done(1'b1, 32'h11112222);
        bus.lsb_addr = 32'h2000; bus.lsb_wr = 1'b0; bus.lsb_ls_type = 3'd2; bus.lsb_req = 1'b1;
        bus.if_addr = 32'h400; bus.if_req = 1'b1;
        wait_for(0, "starve_if");
        check32("age_after_if_grant", 32'(dut.u_age.r_age), 32'd0);
        tick();
        bus.if_addr = 32'h404;
        wait_for(1, "lsb_after_promote");
        tick();
        bus.lsb_req = 1'b0;
        wait_for(0, "if_second");
        tick();
        bus.if_req = 1'b0;
        repeat (2) tick();

        // IO-full store withheld while IF proceeds, then issued once buffer drains
        mc_data = 32'h33334444;
        exp_req(32'h500, MEM_READ, LS_WORD, 32'h0);
        exp_done(1'b1, 32'h33334444);
        bus.io_buffer_full = 1'b1;
        bus.lsb_addr = 32'h30000; bus.lsb_wr = 1'b1; bus.lsb_ls_type = 3'd4;
        bus.lsb_st_val = 32'hCAFEF00D; bus.lsb_req = 1'b1;
        bus.if_addr = 32'h500; bus.if_req = 1'b1;
        wait_for(0, "if_over_io");
        tick();
        bus.if_req = 1'b0;
        repeat (4) tick();
        check32("io_store_withheld", 32'(bus.mc_enable), 32'd0);
        exp_req(32'h30000, MEM_WRITE, 3'd4, 32'hCAFEF00D);
        exp_done(1'b0, 32'h0);
        bus.io_buffer_full = 1'b0;
        wait_for(1, "io_store");
        tick();
        bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0;
        repeat (2) tick();

        // clr two cycles into a load: abort, no done, next grant after the gap
        mc_lat = 6; mc_data = 32'h55556666;
        exp_req(32'h2040, MEM_READ, 3'd1, 32'h0);
        bus.lsb_addr = 32'h2040; bus.lsb_ls_type = 3'd1; bus.lsb_req = 1'b1;
        wait_for(2, "ld_grant");
        tick();
        tick();
        bus.clr = 1'b1; bus.lsb_req = 1'b0;
        tick();
        bus.clr = 1'b0;
        exp_req(32'h2080, MEM_READ, 3'd4, 32'h0);
        exp_done(1'b0, 32'h55556666);
        bus.lsb_addr = 32'h2080; bus.lsb_ls_type = 3'd4; bus.lsb_req = 1'b1;
        @(negedge clk);
        check32("abort_state", 32'(dut.r_state), 32'(ABORT));
        check32("abort_mc_enable", 32'(bus.mc_enable), 32'd1);
        wait_for(1, "ld_after_abort");
        tick();
        bus.lsb_req = 1'b0;
        repeat (2) tick();

        // clr during a store is ignored
        mc_lat = 5; mc_data = 32'h77778888;
        exp_req(32'h4000, MEM_WRITE, 3'd4, 32'h12345678);
        exp_done(1'b0, 32'h0);
        bus.lsb_addr = 32'h4000; bus.lsb_wr = 1'b1; bus.lsb_st_val = 32'h12345678; bus.lsb_req = 1'b1;
        wait_for(2, "st_grant");
        tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        wait_for(1, "st_clr");
        tick();
        bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0;
        repeat (2) tick();

        // rdy low freezes the grant and masks mc_done
        mc_lat = 4; mc_data = 32'h9999AAAA;
        exp_req(32'h700, MEM_READ, LS_WORD, 32'h0);
        exp_done(1'b1, 32'h9999AAAA);
        bus.if_addr = 32'h700; bus.if_req = 1'b1;
        wait_for(2, "rdy_grant");
        tick();
        bus.rdy = 1'b0;
        repeat (3) tick();
        check32("rdy_hold_state", 32'(dut.r_state), 32'(GNT_IF));
        check32("rdy_hold_enable", 32'(bus.mc_enable), 32'd1);
        bus.rdy = 1'b1;
        wait_for(0, "rdy_release");
        tick();
        bus.if_req = 1'b0;
        repeat (2) tick();

        // Asynchronous reset in the middle of an IF grant
        mc_lat = 8; mc_data = 32'h0;
        exp_req(32'h600, MEM_READ, LS_WORD, 32'h0);
        bus.if_addr = 32'h600; bus.if_req = 1'b1;
        wait_for(2, "rst_grant");
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        bus.if_req = 1'b0;
        #1;
        check32("arst_mc_enable", 32'(bus.mc_enable), 32'd0);
        check32("arst_mc_addr", bus.mc_addr, 32'd0);
        check32("arst_mc_ls_type", 32'(bus.mc_ls_type), 32'd0);
        check32("arst_state", 32'(dut.r_state), 32'(IDLE));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check32("post_rst_state", 32'(dut.r_state), 32'(IDLE));
        check32("post_rst_age", 32'(dut.u_age.r_age), 32'd0);
        check32("post_rst_enable", 32'(bus.mc_enable), 32'd0);

        repeat (5) tick();
        check32("req_queue_drained", 32'(req_q.size()), 32'd0);
        check32("done_queue_drained", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
